jk_ff: RTL and testbench

- Edge-triggered JK flip-flop register with asynchronous active-high reset.
- Each bit holds, clears, sets or toggles on the rising clock edge according to its J/K pair.
- Leaf storage primitive for small counters and control logic.
- Default configuration is a single-bit flop; WIDTH generalises it to a bank of independent bits sharing clock and reset.

---
 rtl/jk_ff_pkg.sv | 36 +++
 rtl/jk_ff_bit.sv | 47 ++++
 rtl/jk_ff.sv | 46 ++++
 tb/tb_jk_ff.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/jk_ff_pkg.sv
// ============================================================================
// Module   : jk_ff_pkg
// Purpose  : Shared JK encoding and next-state helper for the jk_ff register.
//            The {J,K} pair is treated as a 2-bit operation code.
// Contents : jk_op_e  - HOLD / CLR / SET / TGL operation names
//            jk_next  - next value of one bit given its op and current state
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package jk_ff_pkg;

  // {J,K} concatenated, J in the MSB.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_op_e;

  function automatic logic jk_next(input jk_op_e op, input logic q);
    logic nxt;
    nxt = q;
    case (op)
      JK_HOLD: nxt = q;
      JK_CLR:  nxt = 1'b0;
      JK_SET:  nxt = 1'b1;
      JK_TGL:  nxt = ~q;
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage : jk_ff_pkg

`default_nettype wire

// File: rtl/jk_ff_bit.sv
// ============================================================================
// Module   : jk_ff_bit
// Purpose  : Single-bit edge-triggered JK flip-flop, asynchronous active-high
//            reset loading a per-instance reset value.
// Ports    : i_j  (in,  1) set / toggle request
//            i_k  (in,  1) clear / toggle request
//            clk  (in,  1) rising-edge clock
//            rst  (in,  1) asynchronous active-high reset
//            o_q  (out, 1) registered state
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_ff_bit
  import jk_ff_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_j,
  input  logic i_k,
  input  logic clk,
  input  logic rst,
  output logic o_q
);

  jk_op_e w_op;
  logic   w_d;
  logic   r_q;

  always_comb begin
    w_op = jk_op_e'({i_j, i_k});
    w_d  = jk_next(w_op, r_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= w_d;
    end
  end

  assign o_q = r_q;

endmodule : jk_ff_bit

`default_nettype wire

// File: rtl/jk_ff.sv
// ============================================================================
// Module   : jk_ff
// Purpose  : Bank of WIDTH independent JK flip-flops sharing clock and an
//            asynchronous active-high reset. Each bit holds, clears, sets or
//            toggles on the rising clock edge according to its own J/K pair.
// Ports    : J    (in,  WIDTH) per-bit set / toggle request
//            K    (in,  WIDTH) per-bit clear / toggle request
//            clk  (in,  1)     rising-edge clock
//            rst  (in,  1)     asynchronous active-high reset
//            Q    (out, WIDTH) registered state
//            Port order is fixed: existing instantiations connect by position.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_ff
  import jk_ff_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] Q
);

  // Bits never interact, so each one is its own flop with its own reset bit.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_ff_bit #(
        .RST_VAL (RST_VAL[i])
      ) u_bit (
        .i_j (J[i]),
        .i_k (K[i]),
        .clk (clk),
        .rst (rst),
        .o_q (Q[i])
      );
    end
  endgenerate

endmodule : jk_ff

`default_nettype wire

// File: tb/tb_jk_ff.sv
// ============================================================================
// Module   : tb_jk_ff
// Purpose  : Self-checking bench for jk_ff. Two instances: the default 1-bit
//            flop and a 4-bit bank with reset value 1010. Expected values come
//            from a behavioural model and are queued at stimulus time; a
//            monitor pops and compares one entry after every rising edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_ff;

  localparam logic [3:0] RV4 = 4'b1010;

  logic       clk;
  logic       rst;
  logic [0:0] j1, k1, q1;
  logic [3:0] j4, k4, q4;

  jk_ff u_dut1 (
    .J   (j1),
    .K   (k1),
    .clk (clk),
    .rst (rst),
    .Q   (q1)
  );

  jk_ff #(
    .WIDTH   (4),
    .RST_VAL (RV4)
  ) u_dut4 (
    .J   (j4),
    .K   (k4),
    .clk (clk),
    .rst (rst),
    .Q   (q4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [0:0] e1;
    logic [3:0] e4;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model state
  logic [0:0] m1;
  logic [3:0] m4;

  // Reference rule per bit: JK as a 2-bit code selecting from a truth table
  // {toggle, set, clear, hold} evaluated with plain arithmetic.
  function automatic logic [3:0] model_next(input logic [3:0] q, input logic [3:0] j,
                                            input logic [3:0] k, input int w);
    logic [3:0] r;
    r = q;
    for (int b = 0; b < w; b++) begin
      int code;
      code = 2 * int'(j[b]) + int'(k[b]);
      if (code == 0)      r[b] = q[b];
      else if (code == 1) r[b] = 1'b0;
      else if (code == 2) r[b] = 1'b1;
      else                r[b] = 1'b1 - q[b];
    end
    return r;
  endfunction

  task automatic check1(input string nm, input logic [0:0] got, input logic [0:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s t=%0t got %b want %b", nm, $time, got, want);
    end
  endtask

  task automatic check4(input string nm, input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s t=%0t got %b want %b", nm, $time, got, want);
    end
  endtask

  // Called at a falling edge: drive inputs, advance the model to what Q must
  // be after the coming rising edge, queue it, then wait for the next fall.
  task automatic step(input logic a_j1, input logic a_k1, input logic [3:0] a_j4,
                      input logic [3:0] a_k4, input logic a_rst);
    exp_t e;
    j1  = a_j1;
    k1  = a_k1;
    j4  = a_j4;
    k4  = a_k4;
    rst = a_rst;
    if (a_rst) begin
      m1 = 1'b0;
      m4 = RV4;
    end else begin
      logic [3:0] t;
      t  = model_next({3'b000, m1}, {3'b000, a_j1}, {3'b000, a_k1}, 1);
      m1 = t[0];
      m4 = model_next(m4, a_j4, a_k4, 4);
    end
    e.e1 = m1;
    e.e4 = m4;
    q_exp.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare one queued expectation shortly after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        exp_t e;
        e = q_exp.pop_front();
        check1("q1_edge", q1, e.e1);
        check4("q4_edge", q4, e.e4);
      end
    end
  end

  initial begin
    int wait_cycles;
    rst = 1'b1;
    j1 = '0; k1 = '0; j4 = '0; k4 = '0;
    m1 = 1'b0;
    m4 = RV4;
    #1;
    // Reset acts before any clock edge.
    check1("q1_async_reset", q1, 1'b0);
    check4("q4_async_reset", q4, RV4);
    // Edge at t=5 still in reset.
    begin
      exp_t e;
      e.e1 = 1'b0;
      e.e4 = RV4;
      q_exp.push_back(e);
    end
    @(negedge clk);                         // t=10: release reset

    // Hold over edges 15, 25
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    // Clear (edge 35), then set (edge 45); 4-bit gets the mixed pattern
    step(1'b0, 1'b1, 4'b0011, 4'b0101, 1'b0);
    check4("q4_mixed_1011", q4, 4'b1011);
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
    check1("q1_set", q1, 1'b1);
    // Toggle over two edges: 1 -> 0 -> 1
    step(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0);
    step(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0);
    check1("q1_toggle_back", q1, 1'b1);

    // Asynchronous reset between edges with Q=1: hold for one edge, then
    // raise rst two time units after the edge.
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check1("q1_mid_reset", q1, 1'b0);
    check4("q4_mid_reset", q4, RV4);
    m1 = 1'b0;
    m4 = RV4;
    @(negedge clk);
    // rst held through the next edge with JK=11: reset wins
    step(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1);
    // Release and resume
    step(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0);

    // Randomised phase with occasional reset
    for (int n = 0; n < 300; n++) begin
      step(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 15) == 0));
    end
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);

    wait_cycles = 0;
    while (q_exp.size() > 0 && wait_cycles < 5) begin
      @(negedge clk);
      wait_cycles++;
    end
    n_checks++;
    if (q_exp.size() != 0) begin
      n_errors++;
      $display("FAIL drain got %0d pending want 0", q_exp.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_jk_ff

`default_nettype wire
